// File: rtl/md_pkg.sv
// Shared definitions for the mul/div writeback scheduler: funct3 codes, FSM states, widths.
package md_pkg;
  localparam int MD_XLEN = 32;
  localparam int MD_TAGW = 7;

  localparam logic [2:0] MD_OP_MUL    = 3'd0;
  localparam logic [2:0] MD_OP_MULH   = 3'd1;
  localparam logic [2:0] MD_OP_MULHSU = 3'd2;
  localparam logic [2:0] MD_OP_MULHU  = 3'd3;
  localparam logic [2:0] MD_OP_DIV    = 3'd4;
  localparam logic [2:0] MD_OP_DIVU   = 3'd5;
  localparam logic [2:0] MD_OP_REM    = 3'd6;
  localparam logic [2:0] MD_OP_REMU   = 3'd7;

  localparam logic [31:0] MD_DIV_OVF_A = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } md_state_e;
endpackage

// File: rtl/md_wb_sched_if.sv
// Issue, engine and writeback signals of the MD scheduler; slave is the scheduler side.
interface md_wb_sched_if #(
  parameter int XLEN = md_pkg::MD_XLEN,
  parameter int TAGW = md_pkg::MD_TAGW
);
  logic            pause;
  logic            flush;
  logic            iss_valid;
  logic [2:0]      iss_op;
  logic [XLEN-1:0] iss_rs1;
  logic [XLEN-1:0] iss_rs2;
  logic [TAGW-1:0] iss_rd;
  logic            eng_start;
  logic [2:0]      eng_op;
  logic [XLEN-1:0] eng_a;
  logic [XLEN-1:0] eng_b;
  logic            eng_done;
  logic [XLEN-1:0] eng_result;
  logic            ex_rd_en;
  logic [TAGW-1:0] ex_rd_add;
  logic [XLEN-1:0] ex_rd_data;
  logic            wb_en;
  logic [TAGW-1:0] wb_add;
  logic [XLEN-1:0] wb_data;
  logic            md_busy;
  logic [TAGW-1:0] md_busy_rd;
  logic            md_pause;

  modport slave (
    input  pause, flush, iss_valid, iss_op, iss_rs1, iss_rs2, iss_rd,
    input  eng_done, eng_result, ex_rd_en, ex_rd_add, ex_rd_data,
    output eng_start, eng_op, eng_a, eng_b,
    output wb_en, wb_add, wb_data, md_busy, md_busy_rd, md_pause
  );

  modport master (
    output pause, flush, iss_valid, iss_op, iss_rs1, iss_rs2, iss_rd,
    output eng_done, eng_result, ex_rd_en, ex_rd_add, ex_rd_data,
    input  eng_start, eng_op, eng_a, eng_b,
    input  wb_en, wb_add, wb_data, md_busy, md_busy_rd, md_pause
  );
endinterface

// File: rtl/md_special.sv
// Divide special cases resolved without the engine: divide by zero and signed overflow.
module md_special
  import md_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            is_special,
  output logic [XLEN-1:0] special_result
);
  logic b_zero;
  logic ovf;

  // op[2] = divide family, op[1] = remainder, op[0] = unsigned
  assign b_zero = (b == '0);
  assign ovf    = !op[0] && (a == XLEN'(MD_DIV_OVF_A)) && (b == '1);

  always_comb begin
    is_special     = 1'b0;
    special_result = '0;
    if (op[2]) begin
      if (b_zero) begin
        is_special     = 1'b1;
        special_result = op[1] ? a : '1;
      end else if (ovf) begin
        is_special     = 1'b1;
        special_result = op[1] ? '0 : a;
      end
    end
  end
endmodule

// File: rtl/md_wb_sched.sv
// Issue/writeback scheduler for the shared mul/div engine; ALU writes take the port first.
module md_wb_sched
  import md_pkg::*;
#(
  parameter int XLEN       = MD_XLEN,
  parameter int TAGW       = MD_TAGW,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          reset,
  md_wb_sched_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  md_state_e       state;
  logic [TAGW-1:0] rd_q;
  logic [XLEN-1:0] res_q;
  logic [SW-1:0]   starve_cnt;
  logic            is_special;
  logic [XLEN-1:0] special_result;
  logic            md_slot;
  logic            accept;
  logic            starve_hit;

  md_special #(.XLEN(XLEN)) u_special (
    .op             (bus.iss_op),
    .a              (bus.iss_rs1),
    .b              (bus.iss_rs2),
    .is_special     (is_special),
    .special_result (special_result)
  );

  // md_slot is the cycle the held result owns the port, whether or not it writes (rd=x0)
  assign md_slot    = (state == HOLD) && !bus.ex_rd_en;
  assign accept     = ((state == IDLE) || md_slot) && bus.iss_valid && !bus.flush && !bus.pause;
  assign starve_hit = (state == HOLD) && bus.ex_rd_en && (starve_cnt >= SW'(STARVE_MAX - 1));

  assign bus.md_busy    = (state != IDLE);
  assign bus.md_busy_rd = rd_q;
  assign bus.md_pause   = (bus.iss_valid && !bus.flush && (state != IDLE) && !md_slot) || starve_hit;

  always_comb begin
    bus.wb_en   = 1'b0;
    bus.wb_add  = '0;
    bus.wb_data = '0;
    if (!reset) begin
      bus.wb_en = 1'b0;
    end else if (bus.ex_rd_en) begin
      bus.wb_en   = 1'b1;
      bus.wb_add  = bus.ex_rd_add;
      bus.wb_data = bus.ex_rd_data;
    end else if ((state == HOLD) && (rd_q[4:0] != 5'd0)) begin
      bus.wb_en   = 1'b1;
      bus.wb_add  = rd_q;
      bus.wb_data = res_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rd_q          <= '0;
      res_q         <= '0;
      starve_cnt    <= '0;
      bus.eng_start <= 1'b0;
      bus.eng_op    <= '0;
      bus.eng_a     <= '0;
      bus.eng_b     <= '0;
    end else begin
      if (bus.eng_done)
        assert (state == RUN) else $error("md_wb_sched: eng_done outside RUN");
      bus.eng_start <= 1'b0;
      case (state)
        RUN:     if (bus.eng_done) begin
                   res_q <= bus.eng_result;
                   state <= HOLD;
                 end
        HOLD:    if (md_slot) state <= IDLE;
        default: state <= state;
      endcase
      if ((state == HOLD) && !md_slot) begin
        if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
      // a same-cycle accept overrides the HOLD->IDLE return above
      if (accept) begin
        bus.eng_op <= bus.iss_op;
        bus.eng_a  <= bus.iss_rs1;
        bus.eng_b  <= bus.iss_rs2;
        rd_q       <= bus.iss_rd;
        if (is_special) begin
          res_q <= special_result;
          state <= HOLD;
        end else begin
          bus.eng_start <= 1'b1;
          state         <= RUN;
        end
      end
    end
  end
endmodule

// File: tb/tb_md_wb_sched.sv
// Directed bench for md_wb_sched: engine is modelled by hand-timed eng_done pulses.
module tb_md_wb_sched;
  import md_pkg::*;

  logic clk;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  md_wb_sched_if bus ();

  md_wb_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] rd);
    bus.iss_valid = 1'b1;
    bus.iss_op    = op;
    bus.iss_rs1   = a;
    bus.iss_rs2   = b;
    bus.iss_rd    = rd;
  endtask

  logic [2:0]  sp_op  [4];
  logic [31:0] sp_a   [4];
  logic [31:0] sp_b   [4];
  logic [31:0] sp_exp [4];

  initial begin
    sp_op[0] = MD_OP_DIVU; sp_a[0] = 32'd100;       sp_b[0] = 32'd0;        sp_exp[0] = 32'hFFFF_FFFF;
    sp_op[1] = MD_OP_REM;  sp_a[1] = 32'h8000_0000; sp_b[1] = 32'hFFFF_FFFF; sp_exp[1] = 32'd0;
    sp_op[2] = MD_OP_DIV;  sp_a[2] = 32'h8000_0000; sp_b[2] = 32'hFFFF_FFFF; sp_exp[2] = 32'h8000_0000;
    sp_op[3] = MD_OP_REMU; sp_a[3] = 32'd123;       sp_b[3] = 32'd0;        sp_exp[3] = 32'd123;

    reset = 1'b0;
    bus.pause = 0; bus.flush = 0; bus.iss_valid = 0; bus.iss_op = 0;
    bus.iss_rs1 = 0; bus.iss_rs2 = 0; bus.iss_rd = 0;
    bus.eng_done = 0; bus.eng_result = 0;
    bus.ex_rd_en = 1; bus.ex_rd_add = 7'd5; bus.ex_rd_data = 32'h1234;
    cyc(); cyc(); #1;
    check("rst_wb_en", bus.wb_en, 0);
    check("rst_wb_add", bus.wb_add, 0);
    check("rst_busy", bus.md_busy, 0);
    check("rst_pause", bus.md_pause, 0);
    check("rst_start", bus.eng_start, 0);
    check("rst_eng_a", bus.eng_a, 0);
    check("rst_busy_rd", bus.md_busy_rd, 0);
    bus.ex_rd_en = 0;
    reset = 1'b1;

    // MUL 7*6 -> rd 5, engine latency 2
    cyc(); issue(MD_OP_MUL, 32'd7, 32'd6, 7'd5); #1;
    check("mul_pause_idle", bus.md_pause, 0);
    cyc(); bus.iss_valid = 0; #1;
    check("mul_start", bus.eng_start, 1);
    check("mul_eng_a", bus.eng_a, 7);
    check("mul_eng_b", bus.eng_b, 6);
    check("mul_eng_op", bus.eng_op, MD_OP_MUL);
    check("mul_busy", bus.md_busy, 1);
    check("mul_busy_rd", bus.md_busy_rd, 5);
    cyc(); #1;
    check("mul_start_once", bus.eng_start, 0);
    cyc(); bus.eng_done = 1; bus.eng_result = 32'd42; #1;
    check("mul_no_early_wb", bus.wb_en, 0);
    cyc(); bus.eng_done = 0; #1;
    check("mul_wb_en", bus.wb_en, 1);
    check("mul_wb_add", bus.wb_add, 5);
    check("mul_wb_data", bus.wb_data, 42);
    cyc(); #1;
    check("mul_busy_drop", bus.md_busy, 0);
    check("mul_wb_off", bus.wb_en, 0);

    // divide special cases resolve next cycle without the engine
    for (int i = 0; i < 4; i++) begin
      cyc(); issue(sp_op[i], sp_a[i], sp_b[i], 7'd3); #1;
      cyc(); bus.iss_valid = 0; #1;
      check("sp_no_start", bus.eng_start, 0);
      check("sp_wb_en", bus.wb_en, 1);
      check("sp_wb_add", bus.wb_add, 3);
      check("sp_wb_data", bus.wb_data, sp_exp[i]);
      cyc(); #1;
      check("sp_idle", bus.md_busy, 0);
    end

    // DIV 0x80000000/1 is not special and needs the engine
    cyc(); issue(MD_OP_DIV, 32'h8000_0000, 32'd1, 7'd2); #1;
    cyc(); bus.iss_valid = 0; #1;
    check("div_start", bus.eng_start, 1);
    check("div_no_wb", bus.wb_en, 0);
    cyc(); bus.eng_done = 1; bus.eng_result = 32'h8000_0000; #1;
    cyc(); bus.eng_done = 0; #1;
    check("div_wb_data", bus.wb_data, 32'h8000_0000);

    // starvation: ALU wins 4 cycles, md_pause on the 4th, MD writes when ALU drops
    cyc(); issue(MD_OP_MUL, 32'd3, 32'd3, 7'd9); #1;
    cyc(); bus.iss_valid = 0; #1;
    cyc(); bus.eng_done = 1; bus.eng_result = 32'd9; #1;
    for (int k = 1; k <= 4; k++) begin
      cyc(); bus.eng_done = 0; bus.ex_rd_en = 1; bus.ex_rd_add = 7'd1;
      bus.ex_rd_data = 32'hAAAA + k; #1;
      check("stv_alu_en", bus.wb_en, 1);
      check("stv_alu_add", bus.wb_add, 1);
      check("stv_alu_data", bus.wb_data, 32'hAAAA + k);
      check("stv_pause", bus.md_pause, (k == 4));
    end
    cyc(); bus.ex_rd_en = 0; #1;
    check("stv_md_en", bus.wb_en, 1);
    check("stv_md_add", bus.wb_add, 9);
    check("stv_md_data", bus.wb_data, 9);
    check("stv_pause_clr", bus.md_pause, 0);
    cyc(); #1;
    check("stv_idle", bus.md_busy, 0);

    // second op waits behind RUN, accepted in the write cycle
    cyc(); issue(MD_OP_MUL, 32'd2, 32'd5, 7'd6); #1;
    cyc(); issue(MD_OP_DIVU, 32'd50, 32'd0, 7'd7); #1;
    check("b2b_start", bus.eng_start, 1);
    check("b2b_pause_run", bus.md_pause, 1);
    cyc(); bus.eng_done = 1; bus.eng_result = 32'd10; #1;
    check("b2b_pause_run2", bus.md_pause, 1);
    cyc(); bus.eng_done = 0; #1;
    check("b2b_pause_free", bus.md_pause, 0);
    check("b2b_wb1_add", bus.wb_add, 6);
    check("b2b_wb1_data", bus.wb_data, 10);
    cyc(); bus.iss_valid = 0; #1;
    check("b2b_wb2_en", bus.wb_en, 1);
    check("b2b_wb2_add", bus.wb_add, 7);
    check("b2b_wb2_data", bus.wb_data, 32'hFFFF_FFFF);
    check("b2b_no_start", bus.eng_start, 0);
    cyc(); #1;
    check("b2b_idle", bus.md_busy, 0);
    check("b2b_no_dup", bus.wb_en, 0);

    // flush / pause block the accept
    cyc(); issue(MD_OP_MUL, 32'd1, 32'd1, 7'd8); bus.flush = 1; #1;
    cyc(); #1;
    check("flush_start", bus.eng_start, 0);
    check("flush_busy", bus.md_busy, 0);
    bus.flush = 0; bus.pause = 1;
    cyc(); #1;
    check("pause_start", bus.eng_start, 0);
    check("pause_busy", bus.md_busy, 0);
    bus.iss_valid = 0; bus.pause = 0;

    // rd = x0 (tag 1): runs, never writes
    cyc(); issue(MD_OP_MUL, 32'd1, 32'd1, 7'h20); #1;
    cyc(); bus.iss_valid = 0; #1;
    check("x0_start", bus.eng_start, 1);
    cyc(); bus.eng_done = 1; bus.eng_result = 32'd1; #1;
    cyc(); bus.eng_done = 0; #1;
    check("x0_busy_hold", bus.md_busy, 1);
    check("x0_no_wb", bus.wb_en, 0);
    cyc(); #1;
    check("x0_idle", bus.md_busy, 0);
    check("x0_no_wb2", bus.wb_en, 0);

    // reset mid-RUN drops the op; engine is held in reset too
    cyc(); issue(MD_OP_MUL, 32'd4, 32'd4, 7'd10); #1;
    cyc(); bus.iss_valid = 0; #1;
    check("rr_start", bus.eng_start, 1);
    reset = 1'b0; #1;
    check("rr_busy", bus.md_busy, 0);
    check("rr_start_clr", bus.eng_start, 0);
    check("rr_eng_a", bus.eng_a, 0);
    check("rr_busy_rd", bus.md_busy_rd, 0);
    cyc(); bus.eng_done = 1; bus.eng_result = 32'd16; #1;
    cyc(); bus.eng_done = 0; reset = 1'b1; #1;
    check("rr_wb_off", bus.wb_en, 0);
    cyc(); #1;
    check("rr_busy2", bus.md_busy, 0);
    check("rr_wb_off2", bus.wb_en, 0);
    check("rr_pause", bus.md_pause, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
